// File: rtl/beat_judge_ctrl.sv
// Rhythm-game beat sequencer: issues one target lane per beat, opens a
// timed hit window, judges single-cycle key pulses as hit or miss and keeps
// score, combo and max-combo until NUM_BEATS beats have been judged.
module beat_judge_ctrl #(
  parameter int BEAT_CYCLES   = 25_000_000,
  parameter int WINDOW_CYCLES = 5_000_000,
  parameter int NUM_BEATS     = 16,
  parameter int SCORE_W       = 16
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic [3:0]         key_pulse,
  output logic [1:0]         target_lane,
  output logic               target_valid,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] combo,
  output logic [SCORE_W-1:0] max_combo,
  output logic [7:0]         beat_idx,
  output logic               busy,
  output logic               done
);

  localparam int TW = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [TW-1:0]      GAP_LAST  = TW'(BEAT_CYCLES - WINDOW_CYCLES - 1);
  localparam logic [TW-1:0]      BEAT_LAST = TW'(BEAT_CYCLES - 1);
  localparam logic [7:0]         LAST_BEAT = 8'(NUM_BEATS);
  localparam logic [SCORE_W-1:0] SAT       = '1;
  localparam logic [3:0]         SEED      = 4'b1001;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    WINDOW,
    HOLD,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    lfsr;
  logic [TW-1:0] timer;

  logic               key_event;
  logic               is_hit;
  logic               window_end;
  logic               judge;
  logic               finished;
  logic [7:0]         idx_next;
  logic [3:0]         lfsr_next;
  logic [SCORE_W-1:0] combo_inc;
  logic [SCORE_W-1:0] score_inc;

  assign target_valid = (state == WINDOW);
  assign target_lane  = target_valid ? lfsr[1:0] : 2'd0;
  assign busy         = (state == GAP) || (state == WINDOW) || (state == HOLD);
  assign done         = (state == DONE);

  // Decode the key event, the end of the beat and the saturating increments.
  always_comb begin
    key_event  = (state == WINDOW) && (key_pulse != 4'b0000);
    is_hit     = (key_pulse == (4'b0001 << lfsr[1:0]));
    window_end = (timer == BEAT_LAST);
    judge      = key_event || ((state == WINDOW) && window_end);
    idx_next   = beat_idx + 8'd1;
    finished   = (state == WINDOW) ? (idx_next == LAST_BEAT) : (beat_idx == LAST_BEAT);
    lfsr_next  = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    combo_inc  = (combo == SAT) ? combo : combo + 1'b1;
    score_inc  = (score == SAT) ? score : score + 1'b1;
  end

  // Beat FSM with timer, lane LFSR, judgement pulses and score bookkeeping.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      lfsr       <= SEED;
      timer      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      combo      <= '0;
      max_combo  <= '0;
      beat_idx   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      if (judge) begin
        beat_idx <= idx_next;
        if (key_event && is_hit) begin
          hit_pulse <= 1'b1;
          score     <= score_inc;
          combo     <= combo_inc;
          if (combo_inc > max_combo) begin
            max_combo <= combo_inc;
          end
        end else begin
          miss_pulse <= 1'b1;
          combo      <= '0;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= GAP;
            timer     <= '0;
            lfsr      <= SEED;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            beat_idx  <= '0;
          end
        end
        GAP: begin
          timer <= timer + 1'b1;
          if (timer == GAP_LAST) begin
            state <= WINDOW;
          end
        end
        WINDOW, HOLD: begin
          if (window_end) begin
            timer <= '0;
            lfsr  <= lfsr_next;
            state <= finished ? DONE : GAP;
          end else begin
            timer <= timer + 1'b1;
            if (key_event) begin
              state <= HOLD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_judge_ctrl.sv
// Directed bench for beat_judge_ctrl: a 4-beat round instance with 16-bit
// counters and a 6-beat instance with 2-bit counters for saturation.
module tb_beat_judge_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] key_pulse;

  logic [1:0]  lane_a, lane_s;
  logic        valid_a, valid_s, hit_a, hit_s, miss_a, miss_s;
  logic [15:0] score_a, combo_a, max_a;
  logic [1:0]  score_s, combo_s, max_s;
  logic [7:0]  idx_a, idx_s;
  logic        busy_a, busy_s, done_a, done_s;

  bit          use_s = 1'b0;
  logic [1:0]  obs_lane;
  logic        obs_valid, obs_hit, obs_miss, obs_busy, obs_done;
  logic [15:0] obs_score, obs_combo, obs_max;
  logic [7:0]  obs_idx;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  beat_judge_ctrl #(.BEAT_CYCLES(10), .WINDOW_CYCLES(4), .NUM_BEATS(4), .SCORE_W(16)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .key_pulse(key_pulse),
    .target_lane(lane_a), .target_valid(valid_a), .hit_pulse(hit_a), .miss_pulse(miss_a),
    .score(score_a), .combo(combo_a), .max_combo(max_a), .beat_idx(idx_a),
    .busy(busy_a), .done(done_a)
  );

  beat_judge_ctrl #(.BEAT_CYCLES(10), .WINDOW_CYCLES(4), .NUM_BEATS(6), .SCORE_W(2)) dut_s (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .key_pulse(key_pulse),
    .target_lane(lane_s), .target_valid(valid_s), .hit_pulse(hit_s), .miss_pulse(miss_s),
    .score(score_s), .combo(combo_s), .max_combo(max_s), .beat_idx(idx_s),
    .busy(busy_s), .done(done_s)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Select which instance the checks observe.
  always_comb begin
    obs_lane  = use_s ? lane_s  : lane_a;
    obs_valid = use_s ? valid_s : valid_a;
    obs_hit   = use_s ? hit_s   : hit_a;
    obs_miss  = use_s ? miss_s  : miss_a;
    obs_busy  = use_s ? busy_s  : busy_a;
    obs_done  = use_s ? done_s  : done_a;
    obs_score = use_s ? {14'd0, score_s} : score_a;
    obs_combo = use_s ? {14'd0, combo_s} : combo_a;
    obs_max   = use_s ? {14'd0, max_s}   : max_a;
    obs_idx   = use_s ? idx_s : idx_a;
  end

  // Count any cycle where either instance raises hit and miss together.
  always @(posedge clk) begin
    #1;
    if ((hit_a && miss_a) || (hit_s && miss_s)) both_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] keys);
    key_pulse = keys;
    tick();
    key_pulse = 4'b0000;
  endtask

  // One full 10-cycle beat starting right after the edge that entered GAP.
  // press_at < 0 means no press inside the window (timeout expected).
  task automatic runBeat(input int lane, input logic [3:0] keys, input int press_at,
                         input logic [3:0] gap_keys, input bit exp_hit);
    for (int g = 0; g < 6; g++) begin
      checkOutput("gap_valid", obs_valid, 1'b0);
      applyStimulus((g == 0) ? gap_keys : 4'b0000);
      if (g == 0 && gap_keys != 4'b0000) begin
        checkOutput("gap_key_hit", obs_hit, 1'b0);
        checkOutput("gap_key_miss", obs_miss, 1'b0);
      end
    end
    checkOutput("window_open", obs_valid, 1'b1);
    checkOutput("target_lane", obs_lane, lane);
    for (int w = 0; w < 4; w++) begin
      applyStimulus((w == press_at) ? keys : 4'b0000);
      if (w == press_at) begin
        checkOutput("judge_hit", obs_hit, exp_hit);
        checkOutput("judge_miss", obs_miss, !exp_hit);
      end
    end
    if (press_at < 0) begin
      checkOutput("timeout_miss", obs_miss, 1'b1);
      checkOutput("timeout_hit", obs_hit, 1'b0);
    end
    checkOutput("window_closed", obs_valid, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, obs_valid, 1'b0);
    checkOutput({tag, "_lane"}, obs_lane, 2'd0);
    checkOutput({tag, "_hit"}, obs_hit, 1'b0);
    checkOutput({tag, "_miss"}, obs_miss, 1'b0);
    checkOutput({tag, "_score"}, obs_score, 16'd0);
    checkOutput({tag, "_combo"}, obs_combo, 16'd0);
    checkOutput({tag, "_max"}, obs_max, 16'd0);
    checkOutput({tag, "_idx"}, obs_idx, 8'd0);
    checkOutput({tag, "_busy"}, obs_busy, 1'b0);
    checkOutput({tag, "_done"}, obs_done, 1'b0);
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    key_pulse = 4'b0000;
    tick();
    tick();
    resetn = 1'b1;
    checkAllZero("reset");

    // First beat with no press times out on lane 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_busy", obs_busy, 1'b1);
    runBeat(1, 4'b0000, -1, 4'b0000, 1'b0);
    checkOutput("t1_idx", obs_idx, 8'd1);
    checkOutput("t1_combo", obs_combo, 16'd0);

    // Start during a round is ignored, then reset in the middle of WINDOW.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("midstart_busy", obs_busy, 1'b1);
    checkOutput("midstart_idx", obs_idx, 8'd1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("mid_window", obs_valid, 1'b1);
    checkOutput("mid_lane", obs_lane, 2'd3);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkAllZero("midreset");

    // Full round of correct presses on lanes 1,3,2,1.
    start = 1'b1;
    tick();
    start = 1'b0;
    runBeat(1, 4'b0010, 0, 4'b0000, 1'b1);
    checkOutput("t2_score1", obs_score, 16'd1);
    runBeat(3, 4'b1000, 1, 4'b0000, 1'b1);
    runBeat(2, 4'b0100, 2, 4'b0000, 1'b1);
    runBeat(1, 4'b0010, 0, 4'b0000, 1'b1);
    checkOutput("t2_score", obs_score, 16'd4);
    checkOutput("t2_combo", obs_combo, 16'd4);
    checkOutput("t2_max", obs_max, 16'd4);
    checkOutput("t2_idx", obs_idx, 8'd4);
    checkOutput("t2_done", obs_done, 1'b1);
    checkOutput("t2_busy", obs_busy, 1'b0);

    // Key pulses in DONE are ignored.
    applyStimulus(4'b0010);
    checkOutput("done_key_hit", obs_hit, 1'b0);
    checkOutput("done_key_score", obs_score, 16'd4);

    // Restart from DONE clears counters and replays lane 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_score", obs_score, 16'd0);
    checkOutput("restart_combo", obs_combo, 16'd0);
    checkOutput("restart_max", obs_max, 16'd0);
    checkOutput("restart_idx", obs_idx, 8'd0);
    checkOutput("restart_done", obs_done, 1'b0);
    runBeat(1, 4'b0010, 1, 4'b0000, 1'b1);
    runBeat(3, 4'b1001, 2, 4'b0000, 1'b0);
    checkOutput("t3_combo", obs_combo, 16'd0);
    checkOutput("t3_max", obs_max, 16'd1);
    checkOutput("t3_score", obs_score, 16'd1);
    runBeat(2, 4'b0000, -1, 4'b0000, 1'b0);
    runBeat(1, 4'b0010, 3, 4'b0100, 1'b1);
    checkOutput("t4_score", obs_score, 16'd2);
    checkOutput("t4_combo", obs_combo, 16'd1);
    checkOutput("t4_max", obs_max, 16'd1);
    checkOutput("t4_idx", obs_idx, 8'd4);
    checkOutput("t4_done", obs_done, 1'b1);

    // Saturation with 2-bit counters over a 6-beat round.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    use_s = 1'b1;
    checkAllZero("s_reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    runBeat(1, 4'b0010, 1, 4'b0000, 1'b1);
    runBeat(3, 4'b1000, 1, 4'b0000, 1'b1);
    runBeat(2, 4'b0100, 1, 4'b0000, 1'b1);
    checkOutput("s_score3", obs_score, 16'd3);
    runBeat(1, 4'b0010, 1, 4'b0000, 1'b1);
    runBeat(2, 4'b0100, 1, 4'b0000, 1'b1);
    runBeat(1, 4'b0010, 1, 4'b0000, 1'b1);
    checkOutput("s_score", obs_score, 16'd3);
    checkOutput("s_combo", obs_combo, 16'd3);
    checkOutput("s_max", obs_max, 16'd3);
    checkOutput("s_idx", obs_idx, 8'd6);
    checkOutput("s_done", obs_done, 1'b1);

    checkOutput("never_both", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
